mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares the single synchronous memory port (13-bit word-addressed block, 1-cycle read latency) between the CPU fetch/operand path (requester 0) and a secondary bus master such as a DMA/loader or the UART device (requester 1). It issues grants in the request cycle, routes the winner's address, data and write strobe to the memory, and returns read data to the owner one cycle later. Fairness comes from round-robin tie-breaking. Atomic sequences use a lock with a starvation timeout.

## Interface
- `ADDR_WIDTH`, 16, request/memory address width
- `DATA_WIDTH`, 16, data width
- `LOCK_TIMEOUT`, 8, consecutive cycles a blocked requester waits before a held lock is broken (≥1, counter width `$clog2(LOCK_TIMEOUT+1)`)

- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low; all state cleared while low
- `rN_req`  in  1  requester N (N=0,1) wants an access this cycle
- `rN_write`  in  1  1 = write, 0 = read
- `rN_lock`  in  1  keep ownership after this grant
- `rN_addr`  in  ADDR_WIDTH  access address
- `rN_wdata`  in  DATA_WIDTH  write data
- `rN_grant`  out  1  access accepted this cycle (combinational)
- `rN_rvalid`  out  1  read data for N valid this cycle (registered)
- `rN_rdata`  out  DATA_WIDTH  equals `mem_rdata`; meaningful only with `rN_rvalid`
- `rN_lock_abort`  out  1  one-cycle pulse: N's lock was broken by timeout
- `mem_enable`  out  1  access issued this cycle
- `mem_write`  out  1  write strobe
- `mem_addr`  out  ADDR_WIDTH  muxed address
- `mem_wdata`  out  DATA_WIDTH  muxed write data
- `mem_rdata`  in  DATA_WIDTH  memory read data, valid one cycle after a read issue

## Operation
- State: IDLE, LOCK0, LOCK1. Also holds `last` (last granted requester), `wait_cnt`, `rd_owner`/`rd_pending`.
- IDLE: one requester → it is granted. Both → the requester ≠ `last` is granted. Neither → no grant, `mem_enable`=0.
- A grant to N with `rN_lock`=1 → LOCKN. Grant with `rN_lock`=0 → stays in or returns to IDLE.
- LOCKN: only N can be granted. Other requests get no grant.
  - Exit to IDLE when N is granted with `rN_lock`=0.
  - Exit to IDLE when `rN_req`=0 and `rN_lock`=0.
  - `rN_req`=0 with `rN_lock`=1 holds the lock with no memory access.
- `wait_cnt`: in LOCKN, increments each cycle the other requester has req=1 and is not granted. Otherwise it clears to 0.
  - Reaching `LOCK_TIMEOUT` → next state IDLE, `last`←N, and `rN_lock_abort` pulses.
  - In that cycle N may still be granted if it requests; its lock bit is ignored.
  - The next cycle the waiter wins the tie.
- `last` updates on every grant.
- Winner's `addr`/`wdata`/`write` drive the `mem_*` outputs. With no grant, `mem_*` hold requester 0's values and `mem_enable`=`mem_write`=0.
- A granted read sets `rd_pending`=1 and `rd_owner`=N for the following cycle. `rN_rvalid` = `rd_pending` & (`rd_owner`==N). A write never raises rvalid.
- Back-to-back reads by alternating owners each return in order, one per cycle.

## Timing
- Reset (`reset`=0) values:
  - state IDLE, `last`=1 (requester 0 wins first tie), `wait_cnt`=0, `rd_pending`=0.
  - All grants, rvalids and aborts are 0. `mem_enable`=`mem_write`=0, forced even when requests are present.
- Grant and `mem_*` are combinational in cycle t. The memory samples at the edge ending t. `rN_rvalid`/`rdata` are valid in t+1. Read latency is 1 cycle and throughput is 1 access per cycle.
- Write lands at the edge ending the grant cycle. A read of the same address granted at t+1 returns the new data.
- Reset asserted mid-lock: returns to IDLE immediately and any pending rvalid is dropped. The cycle after release behaves as post-reset.
- Requests are not queued. An ungranted requester holds its inputs stable until it is granted.
- `wait_cnt` saturates at `LOCK_TIMEOUT`. The abort decision uses the registered count, so a timeout breaks the lock exactly `LOCK_TIMEOUT` blocked cycles after blocking began.

## Test plan
- **Reset/tie:** release reset; r0 and r1 both read (addr 0x10, 0x20) → r0 granted cycle 1, r1 cycle 2. `r0_rvalid` cycle 2, `r1_rvalid` cycle 3, each carrying its own data.
- **Write-then-read:** r1 writes 0xBEEF @0x05, then r0 reads 0x05 the next cycle → `r0_rdata`=0xBEEF with `r0_rvalid` one cycle after the read grant. No rvalid follows the write.
- **Lock:** r0 issues 3 locked reads, the last with lock=0, while r1 requests continuously → r1 is never granted during the 3 reads, then is granted on the 4th cycle.
- **Timeout:** `LOCK_TIMEOUT`=4; r0 holds lock=1 with req=0 while r1 requests → `r0_lock_abort` pulses and r1 is granted in the 5th cycle of waiting.
- **Reset mid-lock:** reset pulsed low during LOCK1 with a read pending → no rvalid. After release, state is IDLE and r0 wins the first tie.
- **Idle:** no requests for 10 cycles → `mem_enable`=0 and no grants, rvalids or aborts.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single 1-cycle-latency synchronous memory port.
// Round-robin tie-break, per-requester lock with a starvation timeout.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int LOCK_TIMEOUT = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  r0_req,
  input  logic                  r0_write,
  input  logic                  r0_lock,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_grant,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  output logic                  r0_lock_abort,
  input  logic                  r1_req,
  input  logic                  r1_write,
  input  logic                  r1_lock,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_grant,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  r1_lock_abort,
  output logic                  mem_enable,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(LOCK_TIMEOUT);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t        state, state_next;
  logic          last, last_next;
  logic [CW-1:0] wait_cnt, wait_next;
  logic          rd_pending, rd_owner;
  logic          g0, g1, abort0, abort1;
  logic          timeout, lock_eff0, lock_eff1;
  logic [CW-1:0] wait_inc;

  assign timeout  = (state != IDLE) && (wait_cnt == TIMEOUT_VAL);
  assign wait_inc = (wait_cnt == TIMEOUT_VAL) ? wait_cnt : wait_cnt + CW'(1);

  always_comb begin
    g0         = 1'b0;
    g1         = 1'b0;
    abort0     = 1'b0;
    abort1     = 1'b0;
    wait_next  = '0;
    state_next = state;
    last_next  = last;
    lock_eff0  = r0_lock;
    lock_eff1  = r1_lock;

    case (state)
      LOCK0: begin
        if (timeout) begin
          // Lock holder keeps priority for this one cycle; the waiter gets it otherwise.
          abort0    = 1'b1;
          lock_eff0 = 1'b0;
          g0        = r0_req;
          g1        = r1_req & ~r0_req;
        end else begin
          g0 = r0_req;
          if (r1_req) wait_next = wait_inc;
        end
      end
      LOCK1: begin
        if (timeout) begin
          abort1    = 1'b1;
          lock_eff1 = 1'b0;
          g1        = r1_req;
          g0        = r0_req & ~r1_req;
        end else begin
          g1 = r1_req;
          if (r0_req) wait_next = wait_inc;
        end
      end
      default: begin
        if (r0_req && r1_req) begin
          g0 = last;
          g1 = ~last;
        end else begin
          g0 = r0_req;
          g1 = r1_req;
        end
      end
    endcase

    if (g0) begin
      state_next = lock_eff0 ? LOCK0 : IDLE;
      last_next  = 1'b0;
    end else if (g1) begin
      state_next = lock_eff1 ? LOCK1 : IDLE;
      last_next  = 1'b1;
    end else if (timeout) begin
      state_next = IDLE;
      last_next  = (state == LOCK1);
    end else if ((state == LOCK0 && !r0_lock) || (state == LOCK1 && !r1_lock)) begin
      state_next = IDLE;
    end
  end

  // Outputs are forced quiet while reset is held, even with requests present.
  assign r0_grant      = g0 & reset;
  assign r1_grant      = g1 & reset;
  assign r0_lock_abort = abort0 & reset;
  assign r1_lock_abort = abort1 & reset;

  assign mem_enable = r0_grant | r1_grant;
  assign mem_write  = r1_grant ? r1_write : (r0_grant & r0_write);
  assign mem_addr   = r1_grant ? r1_addr : r0_addr;
  assign mem_wdata  = r1_grant ? r1_wdata : r0_wdata;

  assign r0_rvalid = rd_pending & ~rd_owner;
  assign r1_rvalid = rd_pending & rd_owner;
  assign r0_rdata  = mem_rdata;
  assign r1_rdata  = mem_rdata;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last       <= 1'b1;
      wait_cnt   <= '0;
      rd_pending <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      state      <= state_next;
      last       <= last_next;
      wait_cnt   <= wait_next;
      rd_pending <= mem_enable & ~mem_write;
      rd_owner   <= r1_grant;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected read returns into a
// scoreboard queue, a separate monitor pops them when rvalid appears.
module tb_mem_arbiter;

  logic        clock, reset;
  logic        r0_req, r0_write, r0_lock, r1_req, r1_write, r1_lock;
  logic [15:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_grant, r0_rvalid, r0_lock_abort, r1_grant, r1_rvalid, r1_lock_abort;
  logic [15:0] r0_rdata, r1_rdata;
  logic        mem_enable, mem_write;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic        owner;
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .LOCK_TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .r0_req(r0_req), .r0_write(r0_write), .r0_lock(r0_lock),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_grant(r0_grant), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r0_lock_abort(r0_lock_abort),
    .r1_req(r1_req), .r1_write(r1_write), .r1_lock(r1_lock),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_grant(r1_grant), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .r1_lock_abort(r1_lock_abort),
    .mem_enable(mem_enable), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // 8K-word memory; unwritten words read back as 0xA500 ^ address.
  logic [15:0] mem_model [int];
  always @(posedge clock) begin
    if (mem_enable) begin
      if (mem_write) mem_model[int'(mem_addr[12:0])] = mem_wdata;
      else if (mem_model.exists(int'(mem_addr[12:0]))) mem_rdata <= mem_model[int'(mem_addr[12:0])];
      else mem_rdata <= 16'hA500 ^ {3'b000, mem_addr[12:0]};
    end
  end

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  // One bus cycle: inputs were driven just after the previous edge; sample at negedge.
  task automatic step(input logic eg0, input logic eg1, input logic ew,
                      input logic ea0, input logic ea1,
                      input logic [15:0] ed, input string nm);
    @(negedge clock);
    $display("cyc=%0d %s g0=%b g1=%b en=%b we=%b addr=%h ab0=%b ab1=%b",
             cyc, nm, r0_grant, r1_grant, mem_enable, mem_write, mem_addr,
             r0_lock_abort, r1_lock_abort);
    check({nm, ".r0_grant"}, 16'(r0_grant), 16'(eg0));
    check({nm, ".r1_grant"}, 16'(r1_grant), 16'(eg1));
    check({nm, ".mem_enable"}, 16'(mem_enable), 16'(eg0 | eg1));
    check({nm, ".mem_write"}, 16'(mem_write), 16'(ew));
    check({nm, ".r0_abort"}, 16'(r0_lock_abort), 16'(ea0));
    check({nm, ".r1_abort"}, 16'(r1_lock_abort), 16'(ea1));
    if ((eg0 || eg1) && !ew) sb.push_back('{owner: eg1, data: ed, due: cyc + 1});
    @(posedge clock);
    #1;
  endtask

  // Monitor: every rvalid must match the oldest expectation due this cycle.
  initial forever begin
    @(negedge clock);
    if (r0_rvalid || r1_rvalid) begin
      checks++;
      if (r0_rvalid && r1_rvalid) begin
        errors++;
        $display("FAIL rvalid_both cyc=%0d got=11 exp=one-hot", cyc);
      end else if (sb.size() == 0 || sb[0].due != cyc) begin
        errors++;
        $display("FAIL rvalid_spurious cyc=%0d got r0v=%b r1v=%b exp=none", cyc, r0_rvalid, r1_rvalid);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("cyc=%0d rvalid owner=%0d data=%h", cyc, r1_rvalid, r1_rvalid ? r1_rdata : r0_rdata);
        if (r1_rvalid !== e.owner || (r1_rvalid ? r1_rdata : r0_rdata) !== e.data) begin
          errors++;
          $display("FAIL rdata cyc=%0d got owner=%0d data=%h exp owner=%0d data=%h",
                   cyc, r1_rvalid, r1_rvalid ? r1_rdata : r0_rdata, e.owner, e.data);
        end
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      checks++;
      errors++;
      $display("FAIL rvalid_missing cyc=%0d got=none exp owner=%0d data=%h", cyc, sb[0].owner, sb[0].data);
      void'(sb.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    r0_req = 1'b1; r0_write = 1'b0; r0_lock = 1'b0; r0_addr = 16'h0010; r0_wdata = 16'h0;
    r1_req = 1'b1; r1_write = 1'b0; r1_lock = 1'b0; r1_addr = 16'h0020; r1_wdata = 16'h0;

    // Reset holds everything quiet despite requests; first tie goes to r0.
    step(0, 0, 0, 0, 0, 16'h0, "reset_hold");
    reset = 1'b1;
    step(1, 0, 0, 0, 0, 16'hA510, "tie_r0");
    r0_req = 1'b0;
    step(0, 1, 0, 0, 0, 16'hA520, "tie_r1");
    r1_req = 1'b0;

    // Write then read-back of the same word.
    r1_req = 1'b1; r1_write = 1'b1; r1_addr = 16'h0005; r1_wdata = 16'hBEEF;
    step(0, 1, 1, 0, 0, 16'h0, "wr_beef");
    r1_req = 1'b0; r1_write = 1'b0; r0_req = 1'b1; r0_addr = 16'h0005;
    step(1, 0, 0, 0, 0, 16'hBEEF, "rd_beef");
    r0_req = 1'b0; r1_req = 1'b1; r1_write = 1'b1; r1_addr = 16'h0006; r1_wdata = 16'h1234;
    step(0, 1, 1, 0, 0, 16'h0, "wr_1234");

    // Locked burst by r0 while r1 keeps requesting.
    r1_write = 1'b0; r1_addr = 16'h0040;
    r0_req = 1'b1; r0_addr = 16'h0030; r0_lock = 1'b1;
    step(1, 0, 0, 0, 0, 16'hA530, "lock_rd1");
    r0_addr = 16'h0031;
    step(1, 0, 0, 0, 0, 16'hA531, "lock_rd2");
    r0_addr = 16'h0032; r0_lock = 1'b0;
    step(1, 0, 0, 0, 0, 16'hA532, "lock_rd3");
    r0_req = 1'b0;
    step(0, 1, 0, 0, 0, 16'hA540, "lock_r1");
    r1_req = 1'b0;

    // Lock held idle by r0; r1 starves 4 cycles, lock broken on the 5th.
    r0_req = 1'b1; r0_addr = 16'h0050; r0_lock = 1'b1;
    step(1, 0, 0, 0, 0, 16'hA550, "to_lock");
    r0_req = 1'b0; r1_req = 1'b1; r1_addr = 16'h0060;
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 16'h0, "to_wait");
    step(0, 1, 0, 1, 0, 16'hA560, "to_break");
    r0_lock = 1'b0; r1_req = 1'b0;
    step(0, 0, 0, 0, 0, 16'h0, "to_after");

    // Reset during LOCK1 with a read in flight: that read must never return.
    r1_req = 1'b1; r1_addr = 16'h0070; r1_lock = 1'b1;
    step(0, 1, 0, 0, 0, 16'hA570, "l1_rd");
    sb.delete(sb.size() - 1);
    reset = 1'b0;
    r0_req = 1'b1; r0_addr = 16'h0080; r1_addr = 16'h0090;
    step(0, 0, 0, 0, 0, 16'h0, "rst_mid");
    reset = 1'b1; r1_lock = 1'b0;
    step(1, 0, 0, 0, 0, 16'hA580, "post_rst_tie");
    r0_req = 1'b0;
    step(0, 1, 0, 0, 0, 16'hA590, "post_rst_r1");
    r1_req = 1'b0;

    // Quiet bus.
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 16'h0, "idle");

    check("sb_drained", 16'(sb.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
